alu_nibble_sequencer: RTL and testbench
=======================================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-nibble initiator for the team's 4-bit combinational ALU slice (ops: 00 add, 01 sub, 10 and, 11 or;
//  flag = carry/borrow, 0 for logic ops). Accepts a WIDTH-bit request over valid/ready and drives the slice
//  one nibble per pass, LSB first, chaining carry/borrow by issuing a second +1/-1 pass when needed.
//  Returns the full-width result and final carry/borrow over valid/ready. Sits between a command source and one ALU slice.
// PARAMETERS
//  NIBBLES  4  number of 4-bit nibbles; operand width W = 4*NIBBLES
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   sequencer can accept (high only in IDLE)
//  req_a        in   W   operand A
//  req_b        in   W   operand B
//  req_op       in   2   operation select, same encoding as the ALU slice
//  rsp_valid    out  1   response present (high only in DONE)
//  rsp_ready    in   1   consumer accepts response
//  rsp_result   out  W   registered full-width result
//  rsp_flag     out  1   final carry (add) / borrow (sub); 0 for and/or
//  alu_a        out  4   to slice operand A
//  alu_b        out  4   to slice operand B
//  alu_op       out  2   to slice op select
//  alu_result   in   4   from slice result (combinational, same cycle)
//  alu_flag     in   1   from slice carry/borrow (same cycle)
//  busy         out  1   high in PASS1/PASS2
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; rsp_result=0, rsp_flag=0, rsp_valid=0, busy=0, req_ready=1,
//   internal nibble index/carry/temp=0. Reset mid-operation aborts; the in-flight request is discarded, no response.
//  alu_a/alu_b/alu_op are combinational from state regs; 4'h0/4'h0/2'b00 in IDLE and DONE.
//  States: IDLE, PASS1, PASS2, DONE.
//  IDLE: req_ready=1. On req_valid: latch a,b,op; nib=0; cin=0; -> PASS1. Otherwise stay.
//  PASS1: alu_a=A[nib], alu_b=B[nib], alu_op=op. Sample alu_result->tmp, alu_flag->c1.
//   If op in {add,sub} and cin=1: -> PASS2.
//   Else: write alu_result into rsp_result[nib]; cin<=alu_flag (0 for and/or); advance.
//  PASS2: alu_a=tmp, alu_b=4'h1, alu_op=op (add: +1 carry-in, sub: -1 borrow-in).
//   Write alu_result into rsp_result[nib]; cin<=c1|alu_flag; advance.
//  Advance: if nib==NIBBLES-1 -> DONE with rsp_flag<=new cin; else nib<=nib+1 -> PASS1.
//  DONE: rsp_valid=1; rsp_result/rsp_flag stable until handshake. On rsp_ready -> IDLE (rsp_result holds last value).
//  Latency: acceptance edge to rsp_valid high = NIBBLES + (#nibbles entered with cin=1) cycles; min NIBBLES, max 2*NIBBLES-1.
//  Width rules: c1 and the PASS2 flag are never both 1; OR is exact. Nibble i = bits [4i+3:4i]. Result wraps mod 2^W.
//  req_valid while not IDLE is ignored (req_ready=0), no queuing. rsp_ready outside DONE ignored.
//  No combinational path req_valid->req_ready or rsp_ready->rsp_valid. rsp_valid and req_ready never high together.
// TESTING (NIBBLES=4)
//  add 0x00FF+0x0001 -> 0x0100, flag 0, rsp_valid 6 cycles after acceptance (2 carry passes)
//  add 0xFFFF+0x0001 -> 0x0000, flag 1, 7 cycles; sub 0x0000-0x0001 -> 0xFFFF, flag 1, 7 cycles
//  sub 0x1234-0x1234 -> 0x0000, flag 0, 4 cycles; and 0xF0F0&0x3C3C -> 0x3030 flag 0; or -> 0xFCFC flag 0
//  Backpressure: hold rsp_ready=0 10 cycles in DONE -> rsp_valid/result stable, req_ready=0, new req_valid ignored
//  Drop rst_n during PASS2 -> all outputs reset values immediately; next request completes correctly
//  Back-to-back: rsp_ready=1, req_valid=1 constantly -> one response per request, IDLE visited 1 cycle between

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives a 4-bit ALU slice one nibble per pass, LSB first,
// and chains carry/borrow by inserting a +1/-1 pass on nibbles entered with cin=1.
module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [1:0]   req_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_flag,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic [1:0]   alu_op,
  input  logic [3:0]   alu_result,
  input  logic         alu_flag,
  output logic         busy
);

  localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [1:0]     op_q;
  logic [NW-1:0]  nib_q;
  logic           cin_q, c1_q, flag_q;
  logic [3:0]     tmp_q;

  logic           is_arith;
  logic           commit;
  logic           carry_out;
  logic           last_nib;

  // Decode of the current pass: whether this cycle finalises a nibble and its outgoing carry
  always_comb begin
    is_arith  = ~op_q[1];
    last_nib  = (nib_q == NW'(NIBBLES - 1));
    commit    = ((state_q == PASS1) && !(is_arith && cin_q)) || (state_q == PASS2);
    carry_out = (state_q == PASS2) ? (c1_q | alu_flag) : (is_arith & alu_flag);
  end

  // Slice drive: operand nibble in PASS1, temp +/- 1 in PASS2, quiet otherwise
  always_comb begin
    alu_a  = 4'h0;
    alu_b  = 4'h0;
    alu_op = 2'b00;
    case (state_q)
      PASS1: begin
        alu_a  = a_q[4*nib_q +: 4];
        alu_b  = b_q[4*nib_q +: 4];
        alu_op = op_q;
      end
      PASS2: begin
        alu_a  = tmp_q;
        alu_b  = 4'h1;
        alu_op = op_q;
      end
      default: ;
    endcase
  end

  // Sequencer FSM: request capture, nibble passes, response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      nib_q   <= '0;
      cin_q   <= 1'b0;
      c1_q    <= 1'b0;
      tmp_q   <= '0;
      res_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_b;
            op_q    <= req_op;
            nib_q   <= '0;
            cin_q   <= 1'b0;
            state_q <= PASS1;
          end
        end
        PASS1: begin
          tmp_q <= alu_result;
          c1_q  <= alu_flag;
          if (is_arith && cin_q) state_q <= PASS2;
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: ;
      endcase

      // PASS1 without pending carry and every PASS2 retire one nibble
      if (commit) begin
        res_q[4*nib_q +: 4] <= alu_result;
        cin_q               <= carry_out;
        if (last_nib) begin
          flag_q  <= carry_out;
          state_q <= DONE;
        end else begin
          nib_q   <= nib_q + NW'(1);
          state_q <= PASS1;
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == DONE);
  assign busy       = (state_q == PASS1) || (state_q == PASS2);
  assign rsp_result = res_q;
  assign rsp_flag   = flag_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with a behavioural 4-bit slice and a full-width reference.
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [W-1:0] req_a, req_b;
  logic [1:0]   req_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_flag;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         alu_flag;
  logic         busy;

  int nchecks = 0;
  int nfails  = 0;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Combinational 4-bit ALU slice
  always_comb begin
    alu_result = 4'h0;
    alu_flag   = 1'b0;
    case (alu_op)
      2'b00: {alu_flag, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_result = alu_a - alu_b; alu_flag = (alu_a < alu_b); end
      2'b10: alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchecks++;
    assert (obs === exp_v)
      else begin
        nfails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
  endtask

  // Full-width reference: result/flag from plain arithmetic; latency counts nibbles with a carry/borrow in
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       output logic [W-1:0] r, output logic f, output int lat);
    longint unsigned m, sa, sb;
    lat = NIBBLES;
    case (op)
      2'b00: begin sa = longint'(a) + longint'(b); r = sa[W-1:0]; f = sa[W]; end
      2'b01: begin r = a - b; f = (a < b); end
      2'b10: begin r = a & b; f = 1'b0; end
      default: begin r = a | b; f = 1'b0; end
    endcase
    if (op[1] == 1'b0) begin
      for (int i = 1; i < NIBBLES; i++) begin
        m  = (64'd1 << (4 * i)) - 64'd1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (op == 2'b00 && ((sa + sb) >> (4 * i)) != 0) lat++;
        if (op == 2'b01 && sa < sb) lat++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_result"}, rsp_result, 0);
    check({tag, "_rsp_flag"}, rsp_flag, 0);
    check({tag, "_alu_drive"}, {alu_a, alu_b, alu_op}, 0);
  endtask

  // Count edges from acceptance until rsp_valid, checking busy/ready along the way (bounded)
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_req_ready_busy"}, req_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Caller is #1 after a rising edge with the DUT idle
  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input int hold);
    logic [W-1:0] er;
    logic         ef;
    int           el, lat;
    model(a, b, op, er, ef, el);
    check({tag, "_idle_ready"}, req_ready, 1);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = W'($urandom); req_b = W'($urandom); req_op = 2'($urandom);
    wait_rsp(tag, lat);
    check({tag, "_latency"}, lat, el);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_result"}, rsp_result, er);
    check({tag, "_flag"}, rsp_flag, ef);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_ready"}, req_ready, 0);
    check({tag, "_done_alu"}, {alu_a, alu_b, alu_op}, 0);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_result"}, rsp_result, er);
      check({tag, "_hold_flag"}, rsp_flag, ef);
      check({tag, "_hold_ready"}, req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_after_valid"}, rsp_valid, 0);
    check({tag, "_after_ready"}, req_ready, 1);
    check({tag, "_after_result"}, rsp_result, er);
  endtask

  logic [W-1:0] ra, rb, er;
  logic [1:0]   rop;
  logic         ef;
  int           el, lat;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Directed boundary cases
    run_txn("add_00ff", 16'h00FF, 16'h0001, 2'b00, 0);
    run_txn("add_ffff", 16'hFFFF, 16'h0001, 2'b00, 0);
    run_txn("sub_0000", 16'h0000, 16'h0001, 2'b01, 0);
    run_txn("sub_eq",   16'h1234, 16'h1234, 2'b01, 0);
    run_txn("and",      16'hF0F0, 16'h3C3C, 2'b10, 0);
    run_txn("or",       16'hF0F0, 16'h3C3C, 2'b11, 0);
    run_txn("backpr",   16'h8765, 16'h9ABC, 2'b00, 10);

    // rsp_ready outside DONE is ignored
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stray_rsp_ready", {req_ready, rsp_valid, busy}, 3'b100);
    rsp_ready = 1'b0;

    // Reset during PASS2 aborts the operation
    req_a = 16'hFFFF; req_b = 16'h0001; req_op = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pass2_alu_b", alu_b, 4'h1);
    check("pass2_alu_a", alu_a, 4'hF);
    check("pass2_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    @(posedge clk); #1;
    check_reset_outputs("midop_reset_held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midop_no_rsp", rsp_valid, 0);
    run_txn("after_reset", 16'h0FFF, 16'h0001, 2'b00, 1);

    // Randomised transactions with occasional carry-heavy operands
    for (int t = 0; t < 30; t++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'h0001;
        1: begin ra = 16'hFFFF; end
        2: begin ra = 16'h0000; end
        default: ;
      endcase
      run_txn("rand", ra, rb, rop, $urandom_range(0, 3));
    end

    // Back-to-back: request and response handshakes held high
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      if (t % 3 == 0) rb = 16'h0001;
      req_a = ra; req_b = rb; req_op = rop;
      model(ra, rb, rop, er, ef, el);
      check("b2b_idle", {req_ready, rsp_valid}, 2'b10);
      @(posedge clk); #1;
      req_a = W'($urandom); req_b = W'($urandom);
      wait_rsp("b2b", lat);
      check("b2b_latency", lat, el);
      check("b2b_result", {rsp_valid, rsp_result}, {1'b1, er});
      check("b2b_flag", rsp_flag, ef);
      check("b2b_exclusive", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_end_idle", {req_ready, rsp_valid, busy}, 3'b100);
    rsp_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule
